// File: rtl/zed_bridge_pkg.sv
// zed_bridge_pkg: shared opcode, FSM state and status-bit definitions for the pin bridge
package zed_bridge_pkg;
  typedef enum logic [2:0] {
    OP_NOP, OP_SEL, OP_WNIB, OP_WR, OP_RD, OP_BYTE, OP_OE, OP_CLR
  } op_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  localparam int ST_BUSY = 0;
  localparam int ST_SEL  = 1;
  localparam int ST_TO   = 2;
  localparam int ST_OVR  = 3;
endpackage

// File: rtl/zed_strobe_sync.sv
// zed_strobe_sync: 2-flop synchroniser with registered rising-edge pulse
module zed_strobe_sync #(
  parameter int   W   = 1,
  parameter logic RST = 1'b0
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);
  logic [W-1:0] s1, s2, prev;
  // RST=1 makes a level held high through reset look old, so only a real edge fires
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1   <= {W{RST}};
      s2   <= {W{RST}};
      prev <= {W{RST}};
      rise <= '0;
    end else begin
      s1   <= d;
      s2   <= s1;
      prev <= s2;
      rise <= s2 & ~prev;
    end
  assign q = s2;
endmodule

// File: rtl/zed_pin_bridge.sv
// zed_pin_bridge: nibble-serial pin command bridge to NUM_CH req/ack channels
// ZED_BRIDGE_UIO_DATA_EN: uio_oe fixed at 8'h0F, synchronised uio_in[7:4] OR-ed into write data
module zed_pin_bridge import zed_bridge_pkg::*; #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        ui_in,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uo_out,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic [3:0]        ch_sel,
  output logic              ch_req,
  output logic              ch_we,
  output logic [DATA_W-1:0] ch_wdata,
  input  logic              ch_ack,
  input  logic [DATA_W-1:0] ch_rdata
);
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t state, state_nx;
  op_t op;
  logic [3:0] nib;
  logic pulse, strb_unused, unused_uio, accept, busy, timed_out;
  logic we, err_sel, err_to, err_ovr;
  logic [DATA_W-1:0] staging, wdata, wdata_nx, rdata_buf;
  logic [7:0] cnt;
  logic [15:0] rb16;

  zed_strobe_sync #(.W(1), .RST(1'b1)) u_strb (
    .clk, .rst_n, .d(ui_in[7]), .q(strb_unused), .rise(pulse)
  );

`ifdef ZED_BRIDGE_UIO_DATA_EN
  logic [3:0] uio_s, uio_rise;
  zed_strobe_sync #(.W(4)) u_uio (
    .clk, .rst_n, .d(uio_in[7:4]), .q(uio_s), .rise(uio_rise)
  );
  assign wdata_nx   = staging | DATA_W'(uio_s);
  assign uio_oe     = 8'h0F;
  assign unused_uio = ^{uio_in[3:0], uio_rise};
`else
  logic [7:0] oe;
  assign wdata_nx   = staging;
  assign uio_oe     = oe;
  assign unused_uio = ^uio_in;
`endif

  assign op        = op_t'(ui_in[6:4]);
  assign nib       = ui_in[3:0];
  assign busy      = state != S_IDLE;
  assign accept    = pulse & ena & ~busy;
  assign timed_out = cnt >= TO;
  assign rb16      = 16'(rdata_buf);
  assign ch_req    = state == S_REQ;
  assign ch_we     = we;
  assign ch_wdata  = wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state == S_IDLE ? (accept && (op == OP_WR || op == OP_RD) ? S_REQ : S_IDLE)
             : state == S_REQ  ? (ch_ack || timed_out ? S_DONE : S_REQ)
             : S_IDLE;
  end

  always_comb begin
    uio_out          = '0;
    uio_out[ST_BUSY] = busy;
    uio_out[ST_SEL]  = err_sel;
    uio_out[ST_TO]   = err_to;
    uio_out[ST_OVR]  = err_ovr;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ch_sel    <= '0;
      staging   <= '0;
      wdata     <= '0;
      rdata_buf <= '0;
      uo_out    <= '0;
      we        <= 1'b0;
      err_sel   <= 1'b0;
      err_to    <= 1'b0;
      err_ovr   <= 1'b0;
      cnt       <= '0;
`ifndef ZED_BRIDGE_UIO_DATA_EN
      oe        <= '0;
`endif
    end else begin
      if (pulse && busy) err_ovr <= 1'b1;
      // cnt counts REQ cycles including the current one, so the abort lands after exactly TIMEOUT
      if (state == S_REQ) begin
        cnt <= cnt == 8'hFF ? cnt : cnt + 8'd1;
        if (ch_ack) begin
          if (!we) begin
            rdata_buf <= ch_rdata;
            uo_out    <= ch_rdata[7:0];
          end
        end else if (timed_out) err_to <= 1'b1;
      end
      if (accept)
        case (op)
          OP_SEL:  if (32'(nib) < NUM_CH) ch_sel <= nib; else err_sel <= 1'b1;
          OP_WNIB: staging <= DATA_W'({staging, nib});
          OP_WR:   begin we <= 1'b1; wdata <= wdata_nx; cnt <= 8'd1; end
          OP_RD:   begin we <= 1'b0; cnt <= 8'd1; end
          OP_BYTE: uo_out <= nib[0] ? rb16[15:8] : rb16[7:0];
`ifndef ZED_BRIDGE_UIO_DATA_EN
          OP_OE:   if (nib[3]) oe[7:4] <= {1'b0, nib[2:0]}; else oe[3:0] <= nib;
`endif
          OP_CLR:  begin err_sel <= 1'b0; err_to <= 1'b0; err_ovr <= 1'b0; staging <= '0; end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_zed_pin_bridge.sv
// tb_zed_pin_bridge: directed bench with a command-level model checked every cycle
module tb_zed_pin_bridge;
  localparam int TO = 15;
  localparam logic [2:0] SEL = 3'd1, WNIB = 3'd2, WR = 3'd3, RD = 3'd4, BYTE = 3'd5, OE = 3'd6, CLR = 3'd7;
`ifdef ZED_BRIDGE_UIO_DATA_EN
  localparam logic [7:0] OE_RST = 8'h0F, OE_END = 8'h0F;
`else
  localparam logic [7:0] OE_RST = 8'h00, OE_END = 8'h45;
`endif

  logic clk = 1'b0, rst_n, ena, ch_ack, ch_req, ch_we;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe, ch_wdata, ch_rdata;
  logic [3:0] ch_sel;
  int n_cmp = 0, n_bad = 0, lat, n;

  zed_pin_bridge #(.NUM_CH(4), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe), .ch_sel(ch_sel),
    .ch_req(ch_req), .ch_we(ch_we), .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_rdata(ch_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a pin rise first sampled at edge k is acted on at edge k+3; transfers tracked as phases
  logic [3:0] h;
  int m_st, m_n;
  logic [3:0] m_sel, nb;
  logic [2:0] op;
  logic [7:0] m_stg, m_wd, m_buf, m_uo, m_oe;
  logic m_we, m_es, m_et, m_eo, e_seen;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h = 4'hF; m_st = 0; m_n = 0; m_sel = 0; m_stg = 0; m_wd = 0; m_buf = 0; m_uo = 0;
      m_oe = OE_RST; m_we = 0; m_es = 0; m_et = 0; m_eo = 0;
    end else begin
      e_seen = h[2] & ~h[3];
      h = {h[2:0], ui_in[7]};
      op = ui_in[6:4];
      nb = ui_in[3:0];
      if (e_seen && m_st != 0) m_eo = 1;
      if (m_st == 1) begin
        m_n++;
        if (ch_ack) begin
          m_st = 2;
          if (!m_we) begin m_buf = ch_rdata; m_uo = ch_rdata; end
        end else if (m_n >= TO) begin
          m_st = 2; m_et = 1;
        end
      end else if (m_st == 2) m_st = 0;
      else if (e_seen && ena)
        case (op)
          SEL:  if (nb < 4) m_sel = nb; else m_es = 1;
          WNIB: m_stg = {m_stg[3:0], nb};
          WR:   begin m_we = 1; m_wd = m_stg; m_st = 1; m_n = 0; end
          RD:   begin m_we = 0; m_st = 1; m_n = 0; end
          BYTE: m_uo = nb[0] ? 8'h00 : m_buf;
`ifndef ZED_BRIDGE_UIO_DATA_EN
          OE:   if (nb[3]) m_oe[7:4] = {1'b0, nb[2:0]}; else m_oe[3:0] = nb;
`endif
          CLR:  begin m_es = 0; m_et = 0; m_eo = 0; m_stg = 0; end
          default: ;
        endcase
    end
  end

  always @(negedge clk) begin
    chk("uo_out", uo_out, m_uo);
    chk("uio_out", uio_out, {4'b0, m_eo, m_et, m_es, m_st != 0});
    chk("uio_oe", uio_oe, m_oe);
    chk("ch_sel", ch_sel, m_sel);
    chk("ch_req", ch_req, m_st == 1);
    if (m_st == 1) chk("ch_we", ch_we, m_we);
    if (m_st == 1 && m_we) chk("ch_wdata", ch_wdata, m_wd);
  end

  task automatic up(input logic [2:0] o, input logic [3:0] v);
    @(negedge clk);
    ui_in = {1'b1, o, v};
  endtask

  task automatic cmd(input logic [2:0] o, input logic [3:0] v);
    up(o, v);
    repeat (4) @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start(input logic [2:0] o, output int l);
    up(o, 4'h0);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!ch_req && l < 20);
    ui_in[7] = 1'b0;
  endtask

  task automatic ack_in(input int d, input logic [7:0] data);
    repeat (d - 1) @(negedge clk);
    ch_rdata = data;
    ch_ack = 1'b1;
    @(negedge clk);
    ch_ack = 1'b0;
  endtask

  initial begin
    rst_n = 0; ena = 1; ui_in = 8'hFF; uio_in = 8'h00; ch_ack = 0; ch_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_req", ch_req, 1'b0);
    chk("rst_oe", uio_oe, OE_RST);
    rst_n = 1;
    repeat (8) @(negedge clk);
    chk("held_level_idle", uio_out, 8'h00);
    ui_in = 8'h00;
    repeat (2) @(negedge clk);
    cmd(SEL, 4'h2); cmd(WNIB, 4'hA); cmd(WNIB, 4'h5);
    start(WR, lat);
    chk("latency", lat, 4);
    chk("wr_sel", ch_sel, 4'h2);
    chk("wr_we", ch_we, 1'b1);
    chk("wr_wdata", ch_wdata, 8'hA5);
    ack_in(3, 8'h00);
    chk("req_drop", ch_req, 1'b0);
    chk("busy_done", uio_out[0], 1'b1);
    @(negedge clk);
    chk("busy_idle", uio_out[0], 1'b0);
    cmd(SEL, 4'h1);
    start(RD, lat);
    ack_in(2, 8'h3C);
    chk("rd_data", uo_out, 8'h3C);
    chk("rd_no_to", uio_out[2], 1'b0);
    cmd(BYTE, 4'h1);
    chk("byte_hi", uo_out, 8'h00);
    cmd(BYTE, 4'h0);
    chk("byte_lo", uo_out, 8'h3C);
    start(RD, lat);
    n = 1;
    for (int i = 0; i < 300 && ch_req; i++) begin
      @(negedge clk);
      if (ch_req) n++;
    end
    chk("to_len", n, TO);
    chk("to_err", uio_out[2], 1'b1);
    repeat (2) @(negedge clk);
    chk("to_keep_uo", uo_out, 8'h3C);
    cmd(CLR, 4'h0);
    chk("clr", uio_out[3:0], 4'h0);
    cmd(SEL, 4'h9);
    chk("sel_bad_keep", ch_sel, 4'h1);
    chk("sel_err", uio_out[1], 1'b1);
    cmd(CLR, 4'h0);
    start(RD, lat);
    repeat (2) @(negedge clk);
    up(SEL, 4'h3);
    repeat (4) @(negedge clk);
    ui_in[7] = 1'b0;
    ack_in(1, 8'h77);
    chk("ovr_err", uio_out[3], 1'b1);
    chk("ovr_ignored", ch_sel, 4'h1);
    chk("ovr_rd", uo_out, 8'h77);
    cmd(CLR, 4'h0);
    start(RD, lat);
    ena = 0;
    ack_in(2, 8'h5A);
    chk("ena_rd", uo_out, 8'h5A);
    cmd(SEL, 4'h0);
    chk("ena_block", ch_sel, 4'h1);
    ena = 1;
    cmd(SEL, 4'h0);
    chk("ena_back", ch_sel, 4'h0);
    cmd(OE, 4'h5); cmd(OE, 4'hC);
    chk("oe", uio_oe, OE_END);
    ch_rdata = 8'hEE; ch_ack = 1;
    @(negedge clk);
    ch_ack = 0;
    @(negedge clk);
    chk("stray_ack", uo_out, 8'h5A);
    start(WR, lat);
    chk("wr2_req", ch_req, 1'b1);
    #2 rst_n = 0;
    #1 chk("async_drop", ch_req, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
